// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/flags, valid/ready handshake on both sides,
// and an iterative shift-add unsigned multiplier.
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             err
);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpNor  = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSlt  = 4'd6;
    localparam logic [3:0] OpSltu = 4'd7;
    localparam logic [3:0] OpSll  = 4'd8;
    localparam logic [3:0] OpSrl  = 4'd9;
    localparam logic [3:0] OpSra  = 4'd10;
    localparam logic [3:0] OpMulu = 4'd11;

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e               r_state;
    state_e               w_state_nxt;

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic                 r_z, r_n, r_c, r_v, r_err;

    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [SHW-1:0]       r_cnt;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_start_mul;
    logic                 w_load_alu;
    logic                 w_load_mul;

    logic                 w_sub;
    logic [WIDTH-1:0]     w_b_op;
    logic [WIDTH:0]       w_sum;
    logic                 w_c_msb;
    logic [SHW-1:0]       w_sh;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;
    logic                 w_err;

    // Handshake and load strobes
    always_comb begin
        w_in_ready  = (r_state == StIdle) && (!r_out_valid || out_ready);
        w_accept    = in_valid && w_in_ready;
        w_start_mul = w_accept && (op == OpMulu);
        w_load_alu  = w_accept && (op != OpMulu);
        w_load_mul  = (r_state == StDone);
    end

    assign in_ready = w_in_ready;

    // Single-cycle datapath; SUB reuses the adder with inverted B and carry-in
    always_comb begin
        w_sub   = (op == OpSub);
        w_b_op  = w_sub ? ~b : b;
        w_sum   = {1'b0, a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
        w_c_msb = a[WIDTH-1] ^ w_b_op[WIDTH-1] ^ w_sum[WIDTH-1];
        w_sh    = b[SHW-1:0];
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        case (op)
            OpAdd, OpSub: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_c_msb ^ w_sum[WIDTH];
            end
            OpAnd:  w_res = a & b;
            OpOr:   w_res = a | b;
            OpNor:  w_res = ~(a | b);
            OpXor:  w_res = a ^ b;
            OpSlt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OpSltu: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OpSll:  w_res = a << w_sh;
            OpSrl:  w_res = a >> w_sh;
            OpSra:  w_res = $signed(a) >>> w_sh;
            OpMulu: w_res = '0;
            default: begin
                w_res = '0;
                w_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: if (w_start_mul) w_state_nxt = StMul;
            StMul:  if (r_cnt == '0) w_state_nxt = StDone;
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift-add multiplier: one multiplier bit per cycle, LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (w_start_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= SHW'(WIDTH - 1);
        end else if (r_state == StMul) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    // A new load on the same edge as a consumer handshake keeps out_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_load_alu) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_z         <= (w_res == '0);
            r_n         <= w_res[WIDTH-1];
            r_c         <= w_c;
            r_v         <= w_v;
            r_err       <= w_err;
        end else if (w_load_mul) begin
            r_out_valid <= 1'b1;
            r_result    <= r_prod[WIDTH-1:0];
            r_z         <= (r_prod[WIDTH-1:0] == '0);
            r_n         <= r_prod[WIDTH-1];
            r_c         <= |r_prod[2*WIDTH-1:WIDTH];
            r_v         <= 1'b0;
            r_err       <= 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign z         = r_z;
    assign n         = r_n;
    assign c         = r_c;
    assign v         = r_v;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=32): hand-computed results and flags,
// multiply latency, backpressure ordering and mid-multiply reset.
module tb_alu_mc;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpNor  = 4'd4;
    localparam logic [3:0] OpXor  = 4'd5;
    localparam logic [3:0] OpSlt  = 4'd6;
    localparam logic [3:0] OpSltu = 4'd7;
    localparam logic [3:0] OpSll  = 4'd8;
    localparam logic [3:0] OpSrl  = 4'd9;
    localparam logic [3:0] OpSra  = 4'd10;
    localparam logic [3:0] OpMulu = 4'd11;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        z, n, c, v, err;

    int n_checks;
    int n_errors;

    alu_mc #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .z         (z),
        .n         (n),
        .c         (c),
        .v         (v),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // flags packed as {z, n, c, v, err}
    task automatic expect_out(input string tag, input logic [31:0] res, input logic [4:0] fl);
        check({tag, "/valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "/result"}, result, res);
        check({tag, "/flags"}, {27'd0, z, n, c, v, err}, {27'd0, fl});
    endtask

    // Offer one op for one cycle; caller guarantees in_ready is high
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        check("issue_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 4'd0;
        a         = '0;
        b         = '0;
        #12;
        check("rst/valid", {31'd0, out_valid}, 32'd0);
        check("rst/result", result, 32'd0);
        check("rst/flags", {27'd0, z, n, c, v, err}, 32'd0);
        check("rst/ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops, one per cycle
        issue(OpAdd, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_out("add_wrap", 32'h0000_0000, 5'b10100);
        issue(OpSub, 32'h8000_0000, 32'h0000_0001);
        expect_out("sub_ovf", 32'h7FFF_FFFF, 5'b00110);
        issue(OpSub, 32'h0000_0001, 32'h0000_0002);
        expect_out("sub_borrow", 32'hFFFF_FFFF, 5'b01000);
        issue(OpSlt, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_out("slt", 32'h0000_0001, 5'b00000);
        issue(OpSltu, 32'hFFFF_FFFF, 32'h0000_0001);
        expect_out("sltu", 32'h0000_0000, 5'b10000);
        issue(OpAnd, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect_out("and", 32'hF000_F000, 5'b01000);
        issue(OpOr, 32'h0000_0012, 32'h0000_0021);
        expect_out("or", 32'h0000_0033, 5'b00000);
        issue(OpNor, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        expect_out("nor", 32'h0000_0000, 5'b10000);
        issue(OpXor, 32'hF0F0_F0F0, 32'hFF00_FF00);
        expect_out("xor", 32'h0FF0_0FF0, 5'b00000);
        issue(OpSra, 32'h8000_0000, 32'd31);
        expect_out("sra31", 32'hFFFF_FFFF, 5'b01000);
        issue(OpSrl, 32'h8000_0000, 32'd31);
        expect_out("srl31", 32'h0000_0001, 5'b00000);
        issue(OpSll, 32'h0000_0001, 32'd0);
        expect_out("sll0", 32'h0000_0001, 5'b00000);
        issue(OpSll, 32'h0000_0001, 32'h0000_0024);
        expect_out("sll_hibits", 32'h0000_0010, 5'b00000);

        // Multiply: latency and operand capture
        issue(OpMulu, 32'h0001_0000, 32'h0001_0000);
        a  = 32'hDEAD_BEEF;
        b  = 32'h1234_5678;
        op = OpAdd;
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("mul_busy_cycles", cnt, 32'd33);
        expect_out("mul_big", 32'h0000_0000, 5'b10100);
        issue(OpMulu, 32'd7, 32'd6);
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("mul_busy_cycles2", cnt, 32'd33);
        expect_out("mul_small", 32'd42, 5'b00000);
        @(negedge clk);
        check("drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: three ADDs, consumer stalled then released
        out_ready = 1'b0;
        op        = OpAdd;
        a         = 32'd1;
        b         = 32'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        expect_out("bp_first", 32'd2, 5'b00000);
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        a = 32'd2;
        b = 32'd2;
        @(negedge clk);
        expect_out("bp_held", 32'd2, 5'b00000);
        check("bp_ready_low2", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        expect_out("bp_second", 32'd4, 5'b00000);
        a = 32'd3;
        b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        expect_out("bp_third", 32'd6, 5'b00000);
        @(negedge clk);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a multiply
        issue(OpMulu, 32'd5, 32'd9);
        repeat (10) @(negedge clk);
        check("mid_mul_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort/valid", {31'd0, out_valid}, 32'd0);
        check("abort/result", result, 32'd0);
        check("abort/flags", {27'd0, z, n, c, v, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort/ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) cnt++;
            @(negedge clk);
        end
        check("abort/no_stale", cnt, 32'd0);

        issue(4'd13, 32'd5, 32'd7);
        expect_out("illegal", 32'd0, 5'b10001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
